// File: rtl/laser_fire_ctrl.sv
// Laser fire controller: debounced fire button, vblank-aligned shot, paced motion, cooldown.
// Build option LASER_AUTOFIRE_EN: a held (debounced) button re-arms the shot from idle.
module laser_fire_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned MOTION_DIV      = 4,
  parameter int unsigned COOLDOWN_FRAMES = 8,
  parameter int unsigned SCREEN_HEIGHT   = 480
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       game_enable_i,
  input  logic       fire_button_i,
  input  logic [9:0] h_pos_i,
  input  logic [9:0] v_pos_i,
  input  logic [9:0] y_laser_i,
  input  logic       killing_alien_i,
  output logic       laser_fire_o,
  output logic       laser_enable_o,
  output logic [7:0] shot_count_o,
  output logic [7:0] hit_count_o
);

  localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DbW-1:0] DbLast =
      DbW'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);
  localparam logic [7:0] LineLast  = 8'((MOTION_DIV > 0) ? MOTION_DIV - 1 : 0);
  localparam logic [7:0] FrameLast = 8'((COOLDOWN_FRAMES > 0) ? COOLDOWN_FRAMES - 1 : 0);
  localparam logic [9:0] VblankStart = 10'(SCREEN_HEIGHT);

  typedef enum logic [2:0] {StIdle, StPending, StFire, StFlight, StCooldown} state_e;

  logic           sync1_q, sync2_q;
  logic           level_q, level_d;
  logic           press_q, press_d;
  logic [DbW-1:0] db_cnt_q, db_cnt_d;

  state_e         state_q, state_d;
  logic [7:0]     line_cnt_q, line_cnt_d;
  logic [7:0]     frame_cnt_q, frame_cnt_d;
  logic [7:0]     shot_q, shot_d;
  logic [7:0]     hit_q, hit_d;
  logic           enable_q, enable_d;

  logic line_tick, frame_tick, vblank, start_req;

  assign line_tick  = (h_pos_i == 10'd0);
  assign frame_tick = line_tick && (v_pos_i == 10'd0);
  assign vblank     = (v_pos_i >= VblankStart);

`ifdef LASER_AUTOFIRE_EN
  assign start_req = press_q | level_q;
`else
  assign start_req = press_q;
`endif

  // Debouncer keeps running even while the game is frozen.
  always_comb begin
    level_d  = level_q;
    press_d  = 1'b0;
    db_cnt_d = '0;
    if (sync2_q != level_q) begin
      if (db_cnt_q >= DbLast) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DbW'(1);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    line_cnt_d  = line_cnt_q;
    frame_cnt_d = frame_cnt_q;
    shot_d      = shot_q;
    hit_d       = hit_q;
    enable_d    = 1'b0;
    if (game_enable_i) begin
      unique case (state_q)
        StIdle: begin
          if (start_req) state_d = StPending;
        end
        StPending: begin
          if (vblank) state_d = StFire;
        end
        StFire: begin
          state_d    = StFlight;
          line_cnt_d = '0;
          shot_d     = shot_q + 8'd1;
        end
        StFlight: begin
          if (line_tick) begin
            if (line_cnt_q == LineLast) begin
              line_cnt_d = '0;
              enable_d   = 1'b1;
            end else begin
              line_cnt_d = line_cnt_q + 8'd1;
            end
          end
          if ((y_laser_i == 10'd0) || killing_alien_i) begin
            state_d     = StCooldown;
            frame_cnt_d = '0;
            if (killing_alien_i && (hit_q != 8'hFF)) hit_d = hit_q + 8'd1;
          end
        end
        StCooldown: begin
          if (COOLDOWN_FRAMES == 0) begin
            state_d = StIdle;
          end else if (frame_tick) begin
            if (frame_cnt_q == FrameLast) state_d = StIdle;
            else frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      db_cnt_q    <= '0;
      state_q     <= StIdle;
      line_cnt_q  <= '0;
      frame_cnt_q <= '0;
      shot_q      <= '0;
      hit_q       <= '0;
      enable_q    <= 1'b0;
    end else begin
      sync1_q     <= fire_button_i;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      press_q     <= press_d;
      db_cnt_q    <= db_cnt_d;
      state_q     <= state_d;
      line_cnt_q  <= line_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      shot_q      <= shot_d;
      hit_q       <= hit_d;
      enable_q    <= enable_d;
    end
  end

  // A motion step pending as the shot ends must not leak into cooldown.
  assign laser_fire_o   = game_enable_i && (state_q == StFire);
  assign laser_enable_o = game_enable_i && enable_q && (state_q == StFlight);
  assign shot_count_o   = shot_q;
  assign hit_count_o    = hit_q;

endmodule

// File: tb/tb_laser_fire_ctrl.sv
// Bench for laser_fire_ctrl: directed + randomized steps against a behavioural shot model.
module tb_laser_fire_ctrl;

  localparam int Db   = 16;
  localparam int Div  = 4;
  localparam int Cool = 8;
  localparam int Sh   = 480;
`ifdef LASER_AUTOFIRE_EN
  localparam bit AutoFire = 1'b1;
`else
  localparam bit AutoFire = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, game_enable, fire_button, killing_alien;
  logic [9:0] h_pos, v_pos, y_laser;
  logic       laser_fire, laser_enable;
  logic [7:0] shot_count, hit_count;

  int n_checks = 0;
  int n_errors = 0;

  // Mini raster: the DUT only sees position values, so frames can be short.
  bit fast;
  int hcnt, lidx;

  // Model: debounced level, shot phases, absolute line count, frames left.
  bit m_level, m_press, m_armed, m_fire, m_fly, m_cool, m_en;
  int m_lines, m_frames_left, m_shots, m_hits;
  bit m_hist[$];

  int fires_seen, enables_seen;

  laser_fire_ctrl #(
    .DEBOUNCE_CYCLES(Db),
    .MOTION_DIV     (Div),
    .COOLDOWN_FRAMES(Cool),
    .SCREEN_HEIGHT  (Sh)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .game_enable_i  (game_enable),
    .fire_button_i  (fire_button),
    .h_pos_i        (h_pos),
    .v_pos_i        (v_pos),
    .y_laser_i      (y_laser),
    .killing_alien_i(killing_alien),
    .laser_fire_o   (laser_fire),
    .laser_enable_o (laser_enable),
    .shot_count_o   (shot_count),
    .hit_count_o    (hit_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] line_v(input int idx);
    if (fast) return (idx == 0) ? 10'd0 : 10'd480;
    if (idx < 10) return 10'(idx * 50);
    return 10'(480 + (idx - 10) * 20);
  endfunction

  task automatic raster_restart(input bit f);
    fast  = f;
    hcnt  = 0;
    lidx  = 0;
    h_pos = 10'd0;
    v_pos = line_v(0);
  endtask

  task automatic raster_advance();
    int hw = fast ? 2 : 8;
    int nl = fast ? 2 : 12;
    hcnt++;
    if (hcnt == hw) begin
      hcnt = 0;
      lidx = (lidx + 1) % nl;
    end
    h_pos = 10'(hcnt);
    v_pos = line_v(lidx);
  endtask

  function automatic bit m_idle();
    return !(m_armed || m_fire || m_fly || m_cool);
  endfunction

  task automatic model_reset();
    m_level = 0; m_press = 0; m_armed = 0; m_fire = 0; m_fly = 0; m_cool = 0; m_en = 0;
    m_lines = 0; m_frames_left = 0; m_shots = 0; m_hits = 0;
    m_hist.delete();
  endtask

  // Applies one clock edge of the shot rules to the model using the inputs seen at that edge.
  task automatic model_edge();
    bit lv_prev = m_level;
    bit pr_prev = m_press;
    bit line, frame, differ;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_en = 0;
    if (game_enable) begin
      line  = (h_pos == 0);
      frame = line && (v_pos == 0);
      if (m_fly) begin
        if (line) begin
          m_lines++;
          if (m_lines % Div == 0) m_en = 1;
        end
        if (y_laser == 0 || killing_alien) begin
          m_fly = 0;
          m_cool = 1;
          m_frames_left = Cool;
          if (killing_alien && m_hits < 255) m_hits++;
        end
      end else if (m_fire) begin
        m_fire = 0;
        m_fly = 1;
        m_lines = 0;
        m_shots = (m_shots + 1) % 256;
      end else if (m_armed) begin
        if (v_pos >= Sh) begin
          m_armed = 0;
          m_fire = 1;
        end
      end else if (m_cool) begin
        if (m_frames_left == 0) m_cool = 0;
        else if (frame) begin
          m_frames_left--;
          if (m_frames_left == 0) m_cool = 0;
        end
      end else if (pr_prev || (AutoFire && lv_prev)) begin
        m_armed = 1;
      end
    end
    // Level accepted when the last Db synchronised samples (2 edges late) all disagree.
    m_press = 0;
    m_hist.push_front(fire_button);
    if (m_hist.size() > Db + 2) void'(m_hist.pop_back());
    if (m_hist.size() == Db + 2) begin
      differ = 1;
      for (int i = 2; i < Db + 2; i++) if (m_hist[i] == m_level) differ = 0;
      if (differ) begin
        m_level = !m_level;
        m_press = m_level;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check("laser_fire", 32'(laser_fire), 32'(m_fire && game_enable));
    check("laser_enable", 32'(laser_enable), 32'(m_en && m_fly && game_enable));
    check("shot_count", 32'(shot_count), 32'(m_shots));
    check("hit_count", 32'(hit_count), 32'(m_hits));
    if (laser_fire) fires_seen++;
    if (laser_enable) enables_seen++;
    @(posedge clk);
    model_edge();
    #1;
    raster_advance();
  endtask

  task automatic run_until_idle(input string tag, input int limit);
    int w = 0;
    while (!(m_idle() && !m_level && !m_press) && w < limit) begin
      tick();
      w++;
    end
    check(tag, 32'(w < limit), 1);
  endtask

  task automatic wait_fly(input string tag, input int limit);
    int w = 0;
    while (!m_fly && w < limit) begin
      tick();
      w++;
    end
    check(tag, 32'(m_fly), 1);
  endtask

  task automatic press(input int cycles);
    fire_button = 1'b1;
    repeat (cycles) tick();
    fire_button = 1'b0;
  endtask

  initial begin
    int w, n;
    rst_n = 1'b0;
    game_enable = 1'b1;
    fire_button = 1'b0;
    killing_alien = 1'b0;
    y_laser = 10'd200;
    fires_seen = 0;
    enables_seen = 0;
    model_reset();
    raster_restart(1'b0);
    repeat (3) tick();
    check("rst_fire", 32'(laser_fire), 0);
    check("rst_enable", 32'(laser_enable), 0);
    check("rst_shots", 32'(shot_count), 0);
    check("rst_hits", 32'(hit_count), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Press held 20 cycles at vPos=100: fire waits for vblank, one pulse only.
    w = 0;
    while (!(v_pos == 10'd100 && h_pos == 10'd0) && w < 200) begin
      tick();
      w++;
    end
    check("wait_v100", 32'(w < 200), 1);
    fires_seen = 0;
    press(20);
    w = 0;
    while (v_pos < 10'(Sh) && w < 200) begin
      tick();
      w++;
    end
    check("no_fire_before_vblank", 32'(fires_seen), 0);
    w = 0;
    while (fires_seen == 0 && w < 300) begin
      tick();
      w++;
    end
    enables_seen = 0;
    repeat (3) tick();
    check("single_fire_pulse", 32'(fires_seen), 1);
    check("shot_after_first", 32'(shot_count), 1);

    // 40 lines of flight give exactly 10 motion steps.
    w = 0;
    while (m_lines < 40 && w < 1000) begin
      tick();
      w++;
    end
    tick();
    check("enables_40_lines", 32'(enables_seen), 10);
    y_laser = 10'd0;
    tick();
    y_laser = 10'd200;

    // Hit, then a press inside the cooldown is dropped; a later press fires.
    run_until_idle("idle_before_hit", 3000);
    press(20);
    wait_fly("fly_hit", 300);
    repeat (10) tick();
    killing_alien = 1'b1;
    tick();
    killing_alien = 1'b0;
    check("hit_after_kill", 32'(hit_count), 1);
    fires_seen = 0;
    repeat (5) tick();
    press(20);
    w = 0;
    while (m_cool && w < 2000) begin
      tick();
      w++;
    end
    repeat (150) tick();
    check("cooldown_press_dropped", 32'(fires_seen), 0);
    check("shots_after_drop", 32'(shot_count), 2);
    press(20);
    wait_fly("fly_after_cooldown", 300);
    check("fire_after_cooldown", 32'(fires_seen), 1);
    check("shots_after_refire", 32'(shot_count), 3);
    y_laser = 10'd0;
    tick();
    y_laser = 10'd200;

    // Glitches shorter than the debounce window never fire.
    for (int i = 0; i < 3; i++) begin
      run_until_idle("idle_glitch", 3000);
      fires_seen = 0;
      press((i == 0) ? 15 : int'($urandom_range(1, 14)));
      repeat (150) tick();
      check("glitch_no_fire", 32'(fires_seen), 0);
    end

    // Randomized shots with frozen-game windows and random end of flight.
    for (int i = 0; i < 6; i++) begin
      run_until_idle("idle_rand", 3000);
      press((i == 0) ? 16 : int'($urandom_range(16, 30)));
      wait_fly("fly_rand", 300);
      repeat ($urandom_range(0, 20)) tick();
      game_enable = 1'b0;
      repeat ($urandom_range(1, 40)) tick();
      game_enable = 1'b1;
      n = int'($urandom_range(1, 12));
      w = 0;
      while (m_fly && m_lines < n && w < 300) begin
        tick();
        w++;
      end
      if ($urandom_range(0, 1) == 1) killing_alien = 1'b1;
      else y_laser = 10'd0;
      tick();
      killing_alien = 1'b0;
      y_laser = 10'd200;
    end

    // Press landing on the flight->cooldown edge, button then kept held.
    run_until_idle("idle_edge_press", 3000);
    press(20);
    wait_fly("fly_edge_press", 300);
    w = 0;
    while (m_level && w < 100) begin
      tick();
      w++;
    end
    fire_button = 1'b1;
    repeat (18) tick();
    y_laser = 10'd0;
    tick();
    y_laser = 10'd200;
    fires_seen = 0;
    w = 0;
    while (m_cool && w < 2000) begin
      tick();
      w++;
    end
    repeat (200) tick();
`ifdef LASER_AUTOFIRE_EN
    check("autofire_refire", 32'(fires_seen), 1);
`else
    check("held_no_refire", 32'(fires_seen), 0);
`endif
    fire_button = 1'b0;
    y_laser = 10'd0;
    run_until_idle("idle_after_hold", 3000);
    y_laser = 10'd200;

    // Fast raster: enough hits to saturate the hit counter and wrap shots.
    raster_restart(1'b1);
    killing_alien = 1'b1;
    for (int i = 0; i < 257; i++) begin
      run_until_idle("idle_sat", 500);
      press(20);
    end
    run_until_idle("idle_sat_end", 500);
    killing_alien = 1'b0;
    check("hits_saturated", 32'(hit_count), 255);
    check("shots_wrapped", 32'(shot_count), 32'(m_shots));

    // Asynchronous reset mid-flight with hitCount at 255.
    press(20);
    wait_fly("fly_before_reset", 300);
    repeat (3) tick();
    check("hits_before_reset", 32'(hit_count), 255);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_fire", 32'(laser_fire), 0);
    check("areset_enable", 32'(laser_enable), 0);
    check("areset_shots", 32'(shot_count), 0);
    check("areset_hits", 32'(hit_count), 0);
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    check("post_reset_hits", 32'(hit_count), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/laser_fire_ctrl.md
LASER_FIRE_CTRL -- requirements
Module: laser_fire_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, consecutive clk cycles a synchronised button level must hold before it is accepted.
REQ-002 SHALL have parameter MOTION_DIV, default 4, number of video lines per laser motion step (range 1..255).
REQ-003 SHALL have parameter COOLDOWN_FRAMES, default 8, number of frames after the laser dies before the next shot is allowed (range 0..255).
REQ-004 SHALL have parameter SCREEN_HEIGHT, default 480, first vPos value of vertical blank.
REQ-005 clk  in  1  system clock, single clock domain.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 gameEnable  in  1  when 0, freezes state, counters and motion pacing.
REQ-008 fireButton  in  1  raw asynchronous player button, active-high.
REQ-009 hPos, vPos  in  10 each  current scan position.
REQ-010 yLaser  in  10  laser vertical position; 0 means no laser on screen.
REQ-011 killingAlien  in  1  the laser hit an alien this cycle.
REQ-012 laserFire  out  1  single-cycle fire command to the laser.
REQ-013 laserEnable  out  1  single-cycle motion step command to the laser.
REQ-014 shotCount  out  8  shots fired, wraps 255->0.
REQ-015 hitCount  out  8  hits scored, saturates at 255.

Function
REQ-016 fireButton SHALL pass through a 2-flop synchroniser, then a debouncer: the stable level changes only after the synchronised level differs from it for DEBOUNCE_CYCLES consecutive cycles; pressEvent = 1-cycle pulse on a stable 0->1 change.
REQ-017 lineTick = (hPos==0); frameTick = (hPos==0 && vPos==0); vblank = (vPos >= SCREEN_HEIGHT).
REQ-018 FSM states: IDLE, PENDING, FIRE, FLIGHT, COOLDOWN.
REQ-019 IDLE->PENDING on pressEvent; PENDING->FIRE on the first cycle with vblank=1; FIRE lasts exactly one cycle, then FLIGHT.
REQ-020 laserFire SHALL be 1 exactly in FIRE-state cycles; shotCount increments on the same edge that leaves FIRE.
REQ-021 FLIGHT->COOLDOWN when yLaser==0 or killingAlien=1; killingAlien in FLIGHT SHALL increment hitCount (saturating); killingAlien in any other state SHALL be ignored.
REQ-022 Line counter SHALL count lineTick modulo MOTION_DIV only in FLIGHT and SHALL clear on FLIGHT entry; laserEnable SHALL be registered and pulse 1 cycle after a lineTick on which the counter equals MOTION_DIV-1.
REQ-023 laserEnable SHALL be 0 outside FLIGHT.
REQ-024 COOLDOWN SHALL count frameTick pulses and go to IDLE after COOLDOWN_FRAMES of them; with COOLDOWN_FRAMES=0 it SHALL go to IDLE on the next cycle.
REQ-025 pressEvent outside IDLE SHALL be dropped, never queued.
REQ-026 gameEnable=0 SHALL hold state and all counters and force laserFire=laserEnable=0; the debouncer SHALL keep running.
REQ-027 A press coinciding with the FLIGHT->COOLDOWN edge SHALL be dropped.

Reset
REQ-028 reset=0 SHALL asynchronously force state IDLE, laserFire=0, laserEnable=0, shotCount=0, hitCount=0, and clear the synchroniser, debouncer and all counters; reset mid-flight SHALL abandon the shot without counting a hit.

Configuration
REQ-029 With LASER_AUTOFIRE_EN defined, IDLE->PENDING SHALL also occur when the debounced level is 1, so a held button re-fires after each cooldown; without it, only pressEvent leaves IDLE.

Verification
REQ-030 Press held 20 cycles at vPos=100 -> no laserFire until vPos=480, then one 1-cycle laserFire; shotCount=1.
REQ-031 Button glitch 10 cycles high (DEBOUNCE_CYCLES=16) -> no PENDING, no laserFire.
REQ-032 FLIGHT with MOTION_DIV=4 over 40 lines -> exactly 10 laserEnable pulses, each 1 cycle after hPos==0.
REQ-033 killingAlien during FLIGHT -> hitCount+1, COOLDOWN; a press during the next 8 frames is dropped; a press after the 8th frameTick fires.
REQ-034 reset=0 asserted mid-FLIGHT with hitCount=255 -> all outputs 0 immediately, without waiting for clk.
REQ-035 LASER_AUTOFIRE_EN defined, button held -> second laserFire after yLaser=0 plus 8 frames plus the next vblank; undefined -> no second shot.
